// File: rtl/byte_word_fifo.sv
// Byte-serial word buffer: assembles bytes into WORD_BYTES-wide words, queues them in a
// DEPTH-entry FIFO and re-serialises them with valid/ready handshakes on both sides.
module byte_word_fifo #(
    parameter int WORD_BYTES = 8,
    parameter int DEPTH      = 4,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 in_byte,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [7:0]                 out_byte,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] word_count,
    output logic                       full,
    output logic                       empty
);
    localparam int W    = 8 * WORD_BYTES;
    localparam int IDXW = $clog2(WORD_BYTES);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORD_BYTES - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    logic [IDXW-1:0] wr_idx_q, wr_idx_d;
    logic [IDXW-1:0] rd_idx_q, rd_idx_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q,  count_d;
    logic [W-1:0]    shadow_q, shadow_d;
    logic [W-1:0]    mem_q [DEPTH];
    logic [W-1:0]    mem_d [DEPTH];

    logic            wr_last;
    logic            rd_last;
    logic            in_fire;
    logic            out_fire;
    logic            push;
    logic            pop;
    logic [W-1:0]    word_in;
    logic [W-1:0]    rd_word;

    // Wire position -> byte lane; the same mapping serves assembly and serialisation.
    function automatic logic [IDXW-1:0] lane_of(input logic [IDXW-1:0] idx);
        return LSB_FIRST ? idx : IDX_LAST - idx;
    endfunction

    function automatic logic [7:0] get_lane(input logic [W-1:0] word,
                                            input logic [IDXW-1:0] lane);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (lane == IDXW'(i)) begin
                b = word[i*8 +: 8];
            end
        end
        return b;
    endfunction

    function automatic logic [W-1:0] put_lane(input logic [W-1:0] word,
                                              input logic [IDXW-1:0] lane,
                                              input logic [7:0] b);
        logic [W-1:0] w;
        w = word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (lane == IDXW'(i)) begin
                w[i*8 +: 8] = b;
            end
        end
        return w;
    endfunction

    // Status and handshakes come only from registered state.
    always_comb begin
        full      = (count_q == CNT_FULL);
        empty     = (count_q == '0);
        wr_last   = (wr_idx_q == IDX_LAST);
        rd_last   = (rd_idx_q == IDX_LAST);
        in_ready  = !(wr_last && full);
        out_valid = !empty;
        out_last  = out_valid && rd_last;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        push      = in_fire && wr_last;
        pop       = out_fire && rd_last;
        rd_word   = mem_q[rd_ptr_q];
        out_byte  = out_valid ? get_lane(rd_word, lane_of(rd_idx_q)) : 8'h00;
        word_in   = put_lane(shadow_q, lane_of(wr_idx_q), in_byte);
    end

    assign word_count = count_q;

    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        mem_d    = mem_q;

        if (flush) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (in_fire) begin
                shadow_d = word_in;
                wr_idx_d = wr_last ? '0 : wr_idx_q + IDXW'(1);
            end
            // The final byte bypasses the shadow so the word lands on this same edge.
            if (push) begin
                mem_d[wr_ptr_q] = word_in;
                wr_ptr_d        = wr_ptr_q + PTRW'(1);
            end
            if (out_fire) begin
                rd_idx_d = rd_last ? '0 : rd_idx_q + IDXW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTRW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shadow_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_byte_word_fifo.sv
// Testbench for byte_word_fifo: word-level queue model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with flushes.
module tb_byte_word_fifo;
    localparam int WB = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          flush;
    logic [CW-1:0] word_count;
    logic          full;
    logic          empty;

    logic [7:0]    b_in_byte;
    logic          b_in_valid;
    logic          b_in_ready;
    logic [7:0]    b_out_byte;
    logic          b_out_valid;
    logic          b_out_ready;
    logic          b_out_last;
    logic          b_flush;
    logic [1:0]    b_word_count;
    logic          b_full;
    logic          b_empty;

    always #5 clk = ~clk;

    byte_word_fifo #(.WORD_BYTES(WB), .DEPTH(DP), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .flush(flush), .word_count(word_count),
        .full(full), .empty(empty)
    );

    byte_word_fifo #(.WORD_BYTES(4), .DEPTH(2), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_byte(b_in_byte), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_byte(b_out_byte), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last), .flush(b_flush), .word_count(b_word_count),
        .full(b_full), .empty(b_empty)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: wire-order bytes; byte k of a word lives at bits [k*8 +: 8].
    logic [127:0] m_fifo[$];
    logic [127:0] m_part;
    int           m_part_n;
    int           m_rd_pos;
    logic         m_ir;
    logic         m_ov;

    function automatic logic m_in_ready();
        return !(m_part_n == WB - 1 && m_fifo.size() == DP);
    endfunction

    function automatic logic [7:0] m_out_byte();
        logic [127:0] w;
        if (m_fifo.size() == 0) return 8'h00;
        w = m_fifo[0];
        return w[m_rd_pos*8 +: 8];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_part   = '0;
            m_part_n = 0;
            m_rd_pos = 0;
        end else if (flush) begin
            m_fifo.delete();
            m_part_n = 0;
            m_rd_pos = 0;
        end else begin
            m_ir = m_in_ready();
            m_ov = (m_fifo.size() != 0);
            if (m_ov && out_ready) begin
                if (m_rd_pos == WB - 1) begin
                    void'(m_fifo.pop_front());
                    m_rd_pos = 0;
                end else begin
                    m_rd_pos++;
                end
            end
            if (in_valid && m_ir) begin
                m_part[m_part_n*8 +: 8] = in_byte;
                if (m_part_n == WB - 1) begin
                    m_fifo.push_back(m_part);
                    m_part_n = 0;
                end else begin
                    m_part_n++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_in_ready",   32'(in_ready),   32'(m_in_ready()));
            chk("cmp_out_valid",  32'(out_valid),  32'(m_fifo.size() != 0));
            chk("cmp_out_byte",   32'(out_byte),   32'(m_out_byte()));
            chk("cmp_out_last",   32'(out_last),   32'(m_fifo.size() != 0 && m_rd_pos == WB - 1));
            chk("cmp_word_count", 32'(word_count), 32'(m_fifo.size()));
            chk("cmp_full",       32'(full),       32'(m_fifo.size() == DP));
            chk("cmp_empty",      32'(empty),      32'(m_fifo.size() == 0));
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
        chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
        chk({tag, "_out_byte"},   32'(out_byte),   32'h00);
        chk({tag, "_out_last"},   32'(out_last),   32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
        chk({tag, "_full"},       32'(full),       32'd0);
        chk({tag, "_empty"},      32'(empty),      32'd1);
    endtask

    task automatic send_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = base + 8'(i);
        end
    endtask

    // Sends base..base+7 with out_ready high and checks the word comes straight back.
    task automatic loopback(input logic [7:0] base, input string tag);
        out_ready = 1'b1;
        send_seq(base, WB);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < WB; k++) begin
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_byte"},  32'(out_byte),  32'(base + 8'(k)));
            chk({tag, "_last"},  32'(out_last),  32'(k == WB - 1));
            if (k == 0) chk({tag, "_count1"}, 32'(word_count), 32'd1);
            @(negedge clk);
        end
        chk({tag, "_count0"}, 32'(word_count), 32'd0);
        chk({tag, "_idle"},   32'(out_valid),  32'd0);
    endtask

    task automatic drain(input int budget, input string tag);
        int c;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while (!(empty === 1'b1 && m_fifo.size() == 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_drained"}, 32'(empty), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b_exp [4];
        int         thr;

        b_exp[0] = 8'hAA; b_exp[1] = 8'hBB; b_exp[2] = 8'hCC; b_exp[3] = 8'hDD;
        rst_n = 1'b0; in_byte = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        b_in_byte = '0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        loopback(8'h01, "loop");

        // Back-pressure: fill four words, park seven bytes of a fifth, stall the eighth.
        out_ready = 1'b0;
        send_seq(8'h00, 32);
        for (int i = 0; i < WB - 1; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = 8'h20;
        end
        @(negedge clk);
        chk("bp_full",  32'(full),       32'd1);
        chk("bp_count", 32'(word_count), 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < WB; k++) begin
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_out_byte",     32'(out_byte), 32'(k));
            @(negedge clk);
        end
        chk("bp_in_ready_rise", 32'(in_ready),   32'd1);
        chk("bp_count_after",   32'(word_count), 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_count_refill", 32'(word_count), 32'd4);
        drain(200, "bp");

        // Last input byte and last output byte on the same edge.
        out_ready = 1'b0;
        send_seq(8'h40, WB);
        send_seq(8'h50, WB);
        send_seq(8'h60, WB - 1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("sim_count_pre", 32'(word_count), 32'd2);
        repeat (WB - 1) @(negedge clk);
        chk("sim_last_byte", 32'(out_byte), 32'h47);
        chk("sim_last_flag", 32'(out_last), 32'd1);
        in_valid = 1'b1;
        in_byte  = 8'h67;
        @(negedge clk);
        in_valid = 1'b0;
        chk("sim_count_post", 32'(word_count), 32'd2);
        chk("sim_next_byte",  32'(out_byte),   32'h50);
        chk("sim_next_last",  32'(out_last),   32'd0);
        drain(200, "sim");

        // Flush mid-input.
        out_ready = 1'b0;
        send_seq(8'h81, 3);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_in_count",  32'(word_count), 32'd0);
        chk("fl_in_valid",  32'(out_valid),  32'd0);
        chk("fl_in_ready",  32'(in_ready),   32'd1);

        // Flush mid-output with both handshakes active in the flush cycle.
        send_seq(8'h90, WB);
        send_seq(8'hA0, 3);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("fl_out_byte5", 32'(out_byte), 32'h95);
        in_valid = 1'b1;
        in_byte  = 8'hEE;
        flush    = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("fl_out_count", 32'(word_count), 32'd0);
        chk("fl_out_valid", 32'(out_valid),  32'd0);
        chk("fl_out_ready", 32'(in_ready),   32'd1);
        chk("fl_out_zero",  32'(out_byte),   32'h00);
        loopback(8'hB0, "fl_fresh");

        // LSB_FIRST=0, four-byte words.
        send_seq(8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_byte  = b_exp[i];
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("msb_word",  dut_b.mem_q[0],     32'hAABBCCDD);
        chk("msb_count", 32'(b_word_count),  32'd1);
        b_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("msb_valid", 32'(b_out_valid), 32'd1);
            chk("msb_byte",  32'(b_out_byte),  32'(b_exp[k]));
            chk("msb_last",  32'(b_out_last),  32'(k == 3));
            @(negedge clk);
        end
        chk("msb_empty", 32'(b_empty), 32'd1);
        b_out_ready = 1'b0;

        // Asynchronous reset between edges while a word is waiting and another is half in.
        out_ready = 1'b0;
        send_seq(8'hC0, WB + 2);
        @(negedge clk);
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("ar");
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        loopback(8'hD0, "ar_loop");

        // Randomized traffic with varying output back-pressure and occasional flushes.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            case ((c / 500) % 4)
                0:       thr = 2;
                1:       thr = 5;
                2:       thr = 9;
                default: thr = 10;
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            in_byte   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < thr);
            flush     = ($urandom_range(0, 63) == 0);
        end
        drain(400, "rnd");

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_word_fifo.md
# byte_word_fifo

Parametrised byte-serial word buffer for the FPU tile's I/O path. It assembles bytes from the 8-bit input pins into WORD_BYTES-wide words and queues them in a DEPTH-entry FIFO. Queued words are re-serialised to the 8-bit output pins with a valid/ready handshake. It replaces the fixed 64-bit single-register write/read pair: width, depth and byte order are configurable, and back-pressure, flush and status reporting are added.

## Interface
- WORD_BYTES, 8, bytes per word (2..16); word width W = 8*WORD_BYTES.
- DEPTH, 4, FIFO entries (power of two, 2..8).
- LSB_FIRST, 1, 1: first byte on the wire maps to word[7:0]; 0: first byte maps to word[W-1:W-8]. Applies to both assembly and serialisation.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_byte  in  8  input data byte.
- in_valid  in  1  in_byte valid this cycle.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_byte  out  8  output byte; 8'h00 when out_valid=0.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  byte consumed when out_valid && out_ready.
- out_last  out  1  out_byte is the final byte of its word (qualified by out_valid).
- flush  in  1  synchronous clear of assembler, serialiser and FIFO.
- word_count  out  $clog2(DEPTH+1)  complete words in FIFO.
- full  out  1  word_count == DEPTH.
- empty  out  1  word_count == 0.

## Operation
- Assembler:
  - Byte counter wr_idx runs 0..WORD_BYTES-1 with a W-bit shadow register.
  - On an accepted byte, the byte goes to lane wr_idx (LSB_FIRST=1) or lane WORD_BYTES-1-wr_idx (LSB_FIRST=0), and wr_idx increments.
  - On accepting the byte at wr_idx==WORD_BYTES-1, the complete word (shadow plus this byte) is written to FIFO[wr_ptr] on the same edge. wr_ptr and word_count then increment, and wr_idx wraps to 0.
- in_ready = !(wr_idx==WORD_BYTES-1 && full).
  - Uses registered full only; a same-cycle pop does not raise in_ready.
  - Bytes 0..WORD_BYTES-2 are always accepted, even when the FIFO is full.
- Serialiser:
  - Reads FIFO[rd_ptr] directly; byte index rd_idx runs 0..WORD_BYTES-1.
  - out_valid = !empty.
  - out_byte = lane rd_idx (LSB_FIRST=1) or lane WORD_BYTES-1-rd_idx (LSB_FIRST=0).
  - out_last = (rd_idx==WORD_BYTES-1).
  - On a handshake, rd_idx increments; on the last byte it wraps to 0, rd_ptr increments and the word is popped.
- Simultaneous push and pop in one cycle: word_count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- The FIFO never overflows or underflows by construction.
- flush has priority over all handshakes in its cycle: wr_idx, rd_idx, pointers and word_count go to 0. Partial input words and partially sent output words are discarded; the shadow register and memory contents are don't-care.
- Reset values: in_ready=1, out_valid=0, out_byte=8'h00, out_last=0, word_count=0, full=0, empty=1. Reset clears all counters and pointers and may assert mid-word at any time.

## Timing
- Latency: the last input byte is accepted at edge N; out_valid=1 with byte 0 of that word in the cycle after edge N (1 cycle).
- Throughput: 1 byte/cycle in and 1 byte/cycle out, sustained while neither side stalls.
- Output is combinational from FIFO registers and rd_idx. Output holds stable while out_valid && !out_ready.
- in_ready depends only on registered state; there is no combinational path from any input.
- out_valid, out_last and out_byte do not depend on out_ready.
- After a flush edge: in_ready=1, out_valid=0 next cycle.

## Test plan
- Defaults, loopback:
  - Stimulus: send bytes 01..08 back-to-back with out_ready=1.
  - Required: out_valid rises in the cycle after the 08 handshake; outputs 01..08 over 8 consecutive cycles; out_last only with 08; word_count 1 then 0.
- LSB_FIRST=0, WORD_BYTES=4:
  - Stimulus: send AA,BB,CC,DD.
  - Required: internal word = 32'hAABBCCDD; output order AA,BB,CC,DD.
- Full / back-pressure (defaults):
  - Stimulus: out_ready=0; send 32 bytes 00..1F, then byte 20 seven times, then attempt an eighth.
  - Required: full=1, word_count=4; the eighth byte sees in_ready=0. Raise out_ready: the first pop of byte 07 lets in_ready rise the next cycle.
- Simultaneous push and pop:
  - Stimulus: word_count=2; the last input byte and the last output byte handshake on the same edge.
  - Required: word_count stays 2; the next word's byte 0 appears at the output the next cycle.
- Flush:
  - Stimulus: assert flush mid-input (3 bytes in) and mid-output (rd_idx=5).
  - Required: the next cycle shows word_count=0, out_valid=0, in_ready=1; a fresh 8-byte word afterwards is output intact with no stale bytes.
- Async reset:
  - Stimulus: drop rst_n between clock edges mid-transfer.
  - Required: outputs go to their reset values immediately, without waiting for a clock edge; normal loopback resumes after release.
